// File: rtl/ex_operand_stage_if.sv
// Bundles the decode-side, forwarding, and ALU-side signals of the ID/EX operand stage.
// The master drives instructions and forwarding data; the slave is the stage itself.
interface ex_operand_stage_if #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [RADDR-1:0] in_rs_addr;
    logic [RADDR-1:0] in_rt_addr;
    logic [RADDR-1:0] in_dest;
    logic [WIDTH-1:0] in_rs_data;
    logic [WIDTH-1:0] in_rt_data;
    logic [15:0]      in_imm;
    logic [4:0]       in_shamt;
    logic [3:0]       in_aluop;
    logic [1:0]       in_alusrc;
    logic             in_shift;
    logic             in_regwrite;

    logic             mem_fwd_en;
    logic [RADDR-1:0] mem_fwd_addr;
    logic [WIDTH-1:0] mem_fwd_data;
    logic             mem_is_load;
    logic             wb_fwd_en;
    logic [RADDR-1:0] wb_fwd_addr;
    logic [WIDTH-1:0] wb_fwd_data;
    logic             flush;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_portA;
    logic [WIDTH-1:0] alu_portB;
    logic [3:0]       alu_op;
    logic [RADDR-1:0] out_dest;
    logic             out_regwrite;
    logic [WIDTH-1:0] out_store_data;

    modport master (
        output in_valid, in_rs_addr, in_rt_addr, in_dest, in_rs_data, in_rt_data,
               in_imm, in_shamt, in_aluop, in_alusrc, in_shift, in_regwrite,
               mem_fwd_en, mem_fwd_addr, mem_fwd_data, mem_is_load,
               wb_fwd_en, wb_fwd_addr, wb_fwd_data, flush, out_ready,
        input  in_ready, out_valid, alu_portA, alu_portB, alu_op, out_dest,
               out_regwrite, out_store_data
    );

    modport slave (
        input  in_valid, in_rs_addr, in_rt_addr, in_dest, in_rs_data, in_rt_data,
               in_imm, in_shamt, in_aluop, in_alusrc, in_shift, in_regwrite,
               mem_fwd_en, mem_fwd_addr, mem_fwd_data, mem_is_load,
               wb_fwd_en, wb_fwd_addr, wb_fwd_data, flush, out_ready,
        output in_ready, out_valid, alu_portA, alu_portB, alu_op, out_dest,
               out_regwrite, out_store_data
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline slot that resolves MEM/WB forwarding, detects load-use hazards,
// and selects the ALU operands for the single held instruction.
module ex_operand_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input logic               CLK,
    input logic               RST,
    ex_operand_stage_if.slave bus
);
    logic             full_q, full_d;
    logic [RADDR-1:0] rsAddr_q, rsAddr_d;
    logic [RADDR-1:0] rtAddr_q, rtAddr_d;
    logic [RADDR-1:0] dest_q, dest_d;
    logic [WIDTH-1:0] rsData_q, rsData_d;
    logic [WIDTH-1:0] rtData_q, rtData_d;
    logic [15:0]      imm_q, imm_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [3:0]       aluop_q, aluop_d;
    logic [1:0]       alusrc_q, alusrc_d;
    logic             shift_q, shift_d;
    logic             regwrite_q, regwrite_d;

    logic             memHitRs, memHitRt, wbHitRs, wbHitRt;
    logic [WIDTH-1:0] fwdRs, fwdRt;
    logic             hazard;
    logic             outValid, inReady, capture, release_;

    assign memHitRs = bus.mem_fwd_en && (bus.mem_fwd_addr == rsAddr_q) && (rsAddr_q != '0);
    assign memHitRt = bus.mem_fwd_en && (bus.mem_fwd_addr == rtAddr_q) && (rtAddr_q != '0);
    assign wbHitRs  = bus.wb_fwd_en  && (bus.wb_fwd_addr  == rsAddr_q) && (rsAddr_q != '0);
    assign wbHitRt  = bus.wb_fwd_en  && (bus.wb_fwd_addr  == rtAddr_q) && (rtAddr_q != '0);

    assign fwdRs = (rsAddr_q == '0) ? '0 :
                   memHitRs ? bus.mem_fwd_data :
                   wbHitRs  ? bus.wb_fwd_data  : rsData_q;
    assign fwdRt = (rtAddr_q == '0) ? '0 :
                   memHitRt ? bus.mem_fwd_data :
                   wbHitRt  ? bus.wb_fwd_data  : rtData_q;

    // rt always feeds out_store_data, so a pending load into rt must stall regardless of alusrc.
    assign hazard   = bus.mem_is_load && ((memHitRs && !shift_q) || memHitRt);
    assign outValid = full_q && !hazard && !bus.flush;
    assign inReady  = !full_q || (outValid && bus.out_ready);
    assign capture  = bus.in_valid && inReady;
    assign release_ = outValid && bus.out_ready;

    assign bus.out_valid      = outValid;
    assign bus.in_ready       = inReady;
    assign bus.alu_op         = aluop_q;
    assign bus.out_dest       = dest_q;
    assign bus.out_regwrite   = regwrite_q;
    assign bus.out_store_data = fwdRt;
    assign bus.alu_portA      = shift_q ? {{(WIDTH-5){1'b0}}, shamt_q} : fwdRs;

    always_comb begin
        bus.alu_portB = fwdRt;
        if (!shift_q) begin
            case (alusrc_q)
                2'd1:    bus.alu_portB = WIDTH'($signed(imm_q));
                2'd2:    bus.alu_portB = WIDTH'(imm_q);
                2'd3:    bus.alu_portB = WIDTH'({imm_q, 16'h0000});
                default: bus.alu_portB = fwdRt;
            endcase
        end
    end

    // A stalled slot absorbs WB results so the value survives once WB retires.
    always_comb begin
        full_d     = full_q;
        rsAddr_d   = rsAddr_q;
        rtAddr_d   = rtAddr_q;
        dest_d     = dest_q;
        rsData_d   = rsData_q;
        rtData_d   = rtData_q;
        imm_d      = imm_q;
        shamt_d    = shamt_q;
        aluop_d    = aluop_q;
        alusrc_d   = alusrc_q;
        shift_d    = shift_q;
        regwrite_d = regwrite_q;
        if (bus.flush) begin
            full_d = 1'b0;
        end else if (capture) begin
            full_d     = 1'b1;
            rsAddr_d   = bus.in_rs_addr;
            rtAddr_d   = bus.in_rt_addr;
            dest_d     = bus.in_dest;
            rsData_d   = bus.in_rs_data;
            rtData_d   = bus.in_rt_data;
            imm_d      = bus.in_imm;
            shamt_d    = bus.in_shamt;
            aluop_d    = bus.in_aluop;
            alusrc_d   = bus.in_alusrc;
            shift_d    = bus.in_shift;
            regwrite_d = bus.in_regwrite;
        end else if (release_) begin
            full_d = 1'b0;
        end else if (full_q) begin
            if (wbHitRs) rsData_d = bus.wb_fwd_data;
            if (wbHitRt) rtData_d = bus.wb_fwd_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            full_q     <= 1'b0;
            rsAddr_q   <= '0;
            rtAddr_q   <= '0;
            dest_q     <= '0;
            rsData_q   <= '0;
            rtData_q   <= '0;
            imm_q      <= '0;
            shamt_q    <= '0;
            aluop_q    <= '0;
            alusrc_q   <= '0;
            shift_q    <= 1'b0;
            regwrite_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            rsAddr_q   <= rsAddr_d;
            rtAddr_q   <= rtAddr_d;
            dest_q     <= dest_d;
            rsData_q   <= rsData_d;
            rtData_q   <= rtData_d;
            imm_q      <= imm_d;
            shamt_q    <= shamt_d;
            aluop_q    <= aluop_d;
            alusrc_q   <= alusrc_d;
            shift_q    <= shift_d;
            regwrite_q <= regwrite_d;
        end
    end
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: stimulus pushes hand-computed results into a
// queue, and a forked monitor pops and compares on every accepted ALU transfer.
module tb_ex_operand_stage;
    typedef struct packed {
        logic [31:0] portA;
        logic [31:0] portB;
        logic [3:0]  op;
        logic [4:0]  dest;
        logic        regwrite;
        logic [31:0] store;
    } expect_t;

    logic    CLK = 1'b0;
    logic    RST;
    int      tests = 0;
    int      fails = 0;
    expect_t expQ[$];

    ex_operand_stage_if #(.WIDTH(32), .RADDR(5)) bus ();

    ex_operand_stage #(.WIDTH(32), .RADDR(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents one instruction; when expectOut is set its hand-computed ALU result is queued.
    task automatic applyStimulus(
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
        input logic [31:0] rsData, input logic [31:0] rtData,
        input logic [15:0] imm, input logic [4:0] shamt, input logic [3:0] aluop,
        input logic [1:0] alusrc, input logic shift, input logic regwrite,
        input logic expectOut, input logic [31:0] expA, input logic [31:0] expB,
        input logic [31:0] expStore);
        expect_t e;
        bus.in_valid    = 1'b1;
        bus.in_rs_addr  = rs;
        bus.in_rt_addr  = rt;
        bus.in_dest     = dest;
        bus.in_rs_data  = rsData;
        bus.in_rt_data  = rtData;
        bus.in_imm      = imm;
        bus.in_shamt    = shamt;
        bus.in_aluop    = aluop;
        bus.in_alusrc   = alusrc;
        bus.in_shift    = shift;
        bus.in_regwrite = regwrite;
        if (expectOut) begin
            e.portA    = expA;
            e.portB    = expB;
            e.op       = aluop;
            e.dest     = dest;
            e.regwrite = regwrite;
            e.store    = expStore;
            expQ.push_back(e);
        end
    endtask

    initial begin
        RST = 1'b1;
        bus.in_valid = 0; bus.in_rs_addr = 0; bus.in_rt_addr = 0; bus.in_dest = 0;
        bus.in_rs_data = 0; bus.in_rt_data = 0; bus.in_imm = 0; bus.in_shamt = 0;
        bus.in_aluop = 0; bus.in_alusrc = 0; bus.in_shift = 0; bus.in_regwrite = 0;
        bus.mem_fwd_en = 0; bus.mem_fwd_addr = 0; bus.mem_fwd_data = 0; bus.mem_is_load = 0;
        bus.wb_fwd_en = 0; bus.wb_fwd_addr = 0; bus.wb_fwd_data = 0;
        bus.flush = 0; bus.out_ready = 1;

        fork
            forever begin
                @(negedge CLK);
                if (!RST && bus.out_valid && bus.out_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedOut", {27'b0, bus.out_dest}, 32'hFFFF_FFFF);
                    end else begin
                        expect_t e;
                        e = expQ.pop_front();
                        checkOutput("monPortA", bus.alu_portA, e.portA);
                        checkOutput("monPortB", bus.alu_portB, e.portB);
                        checkOutput("monOp", {28'b0, bus.alu_op}, {28'b0, e.op});
                        checkOutput("monDest", {27'b0, bus.out_dest}, {27'b0, e.dest});
                        checkOutput("monRegwrite", {31'b0, bus.out_regwrite}, {31'b0, e.regwrite});
                        checkOutput("monStore", bus.out_store_data, e.store);
                    end
                end
            end
        join_none

        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        #1;
        checkOutput("rstValid", {31'b0, bus.out_valid}, 0);
        checkOutput("rstReady", {31'b0, bus.in_ready}, 1);
        checkOutput("rstPortA", bus.alu_portA, 0);
        checkOutput("rstPortB", bus.alu_portB, 0);
        checkOutput("rstOp", {28'b0, bus.alu_op}, 0);
        checkOutput("rstDest", {27'b0, bus.out_dest}, 0);
        checkOutput("rstRegwrite", {31'b0, bus.out_regwrite}, 0);
        checkOutput("rstStore", bus.out_store_data, 0);

        // ADDI r4 = r3 + sext(0xFFFF)
        applyStimulus(3, 0, 4, 32'h10, 0, 16'hFFFF, 0, 4'd0, 2'd1, 0, 1, 1, 32'h10, 32'hFFFF_FFFF, 0);
        step();
        bus.in_valid = 0;
        checkOutput("addiValid", {31'b0, bus.out_valid}, 1);
        step();

        // MEM result beats WB, WB beats held value, r0 ignores both
        bus.out_ready = 0;
        applyStimulus(5, 0, 6, 32'h1111, 0, 16'h0, 0, 4'd0, 2'd1, 0, 1, 1, 32'hBBBB, 0, 0);
        step();
        bus.in_valid = 0;
        bus.mem_fwd_en = 1; bus.mem_fwd_addr = 5; bus.mem_fwd_data = 32'hAAAA;
        bus.wb_fwd_en = 1;  bus.wb_fwd_addr = 5;  bus.wb_fwd_data = 32'hBBBB;
        #1;
        checkOutput("memOverWb", bus.alu_portA, 32'hAAAA);
        checkOutput("memFwdValid", {31'b0, bus.out_valid}, 1);
        bus.mem_fwd_en = 0;
        #1;
        checkOutput("wbOnly", bus.alu_portA, 32'hBBBB);
        bus.out_ready = 1;
        step();
        bus.out_ready = 0;
        bus.mem_fwd_en = 1; bus.mem_fwd_addr = 0; bus.wb_fwd_addr = 0;
        applyStimulus(0, 0, 10, 32'h2222, 0, 16'h0, 0, 4'd0, 2'd1, 0, 1, 1, 0, 0, 0);
        step();
        bus.in_valid = 0;
        #1;
        checkOutput("rsZero", bus.alu_portA, 0);
        bus.out_ready = 1;
        step();
        bus.mem_fwd_en = 0; bus.wb_fwd_en = 0;

        // Load-use on rt, resolved by WB, value kept after WB retires
        applyStimulus(0, 7, 8, 0, 32'h5555, 16'h0, 0, 4'd1, 2'd0, 0, 1, 1, 0, 32'h1234, 32'h1234);
        bus.mem_fwd_en = 1; bus.mem_fwd_addr = 7; bus.mem_fwd_data = 32'hDEAD; bus.mem_is_load = 1;
        step();
        bus.in_valid = 0;
        checkOutput("loadUseValid", {31'b0, bus.out_valid}, 0);
        checkOutput("loadUseReady", {31'b0, bus.in_ready}, 0);
        bus.mem_fwd_en = 0; bus.mem_is_load = 0;
        bus.wb_fwd_en = 1; bus.wb_fwd_addr = 7; bus.wb_fwd_data = 32'h1234;
        bus.out_ready = 0;
        #1;
        checkOutput("wbResolveValid", {31'b0, bus.out_valid}, 1);
        checkOutput("wbResolvePortB", bus.alu_portB, 32'h1234);
        step();
        bus.wb_fwd_en = 0;
        #1;
        checkOutput("persistPortB", bus.alu_portB, 32'h1234);
        checkOutput("persistStore", bus.out_store_data, 32'h1234);
        bus.out_ready = 1;
        step();

        // Back-pressure for 3 cycles, then back-to-back streaming
        bus.out_ready = 0;
        applyStimulus(1, 0, 9, 32'h100, 0, 16'h8001, 0, 4'd2, 2'd2, 0, 1, 1, 32'h100, 32'h8001, 0);
        step();
        applyStimulus(11, 0, 1, 32'h1000, 0, 16'h1, 0, 4'd1, 2'd1, 0, 0, 1, 32'h1000, 32'h1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("bpReady", {31'b0, bus.in_ready}, 0);
            checkOutput("bpPortA", bus.alu_portA, 32'h100);
            checkOutput("bpOp", {28'b0, bus.alu_op}, 2);
            step();
        end
        bus.out_ready = 1;
        #1;
        checkOutput("bpRelease", {31'b0, bus.in_ready}, 1);
        step();
        applyStimulus(12, 0, 2, 32'h2000, 0, 16'h2, 0, 4'd2, 2'd1, 0, 0, 1, 32'h2000, 32'h2, 0);
        #1 checkOutput("streamValid", {31'b0, bus.out_valid}, 1);
        step();
        applyStimulus(13, 0, 3, 32'h3000, 0, 16'h3, 0, 4'd3, 2'd1, 0, 0, 1, 32'h3000, 32'h3, 0);
        #1 checkOutput("streamValid", {31'b0, bus.out_valid}, 1);
        step();
        applyStimulus(14, 0, 4, 32'h4000, 0, 16'h4, 0, 4'd4, 2'd1, 0, 0, 1, 32'h4000, 32'h4, 0);
        #1 checkOutput("streamValid", {31'b0, bus.out_valid}, 1);
        step();
        bus.in_valid = 0;
        #1 checkOutput("streamValid", {31'b0, bus.out_valid}, 1);
        step();

        // SLL by 4, then LUI 0x1234
        applyStimulus(2, 3, 5, 32'hFFFF, 32'h1, 16'h0, 5'd4, 4'd3, 2'd0, 1, 1, 1, 32'h4, 32'h1, 32'h1);
        step();
        applyStimulus(0, 0, 6, 0, 0, 16'h1234, 0, 4'd4, 2'd3, 0, 1, 1, 0, 32'h1234_0000, 0);
        step();
        bus.in_valid = 0;
        step();

        // Flush of a held instruction, then flush dropping a capture into an empty slot
        bus.out_ready = 0;
        applyStimulus(1, 0, 7, 32'h77, 0, 16'h1, 0, 4'd0, 2'd1, 0, 1, 0, 0, 0, 0);
        step();
        applyStimulus(1, 0, 8, 32'h88, 0, 16'h1, 0, 4'd0, 2'd1, 0, 1, 0, 0, 0, 0);
        bus.flush = 1;
        #1 checkOutput("flushComb", {31'b0, bus.out_valid}, 0);
        step();
        bus.flush = 0; bus.in_valid = 0;
        #1;
        checkOutput("flushEmpty", {31'b0, bus.out_valid}, 0);
        checkOutput("flushEmptyReady", {31'b0, bus.in_ready}, 1);
        applyStimulus(1, 0, 9, 32'h99, 0, 16'h1, 0, 4'd0, 2'd1, 0, 1, 0, 0, 0, 0);
        bus.flush = 1;
        #1 checkOutput("flushReady", {31'b0, bus.in_ready}, 1);
        step();
        bus.flush = 0; bus.in_valid = 0;
        #1 checkOutput("flushDrop", {31'b0, bus.out_valid}, 0);
        bus.out_ready = 1;
        step();
        step();

        // Asynchronous reset while the slot is full
        bus.out_ready = 0;
        applyStimulus(1, 0, 3, 32'h55, 0, 16'h1, 0, 4'd5, 2'd1, 0, 1, 0, 0, 0, 0);
        step();
        bus.in_valid = 0;
        checkOutput("preResetValid", {31'b0, bus.out_valid}, 1);
        RST = 1'b1;
        #1;
        checkOutput("asyncRstValid", {31'b0, bus.out_valid}, 0);
        checkOutput("asyncRstPortA", bus.alu_portA, 0);
        checkOutput("asyncRstReady", {31'b0, bus.in_ready}, 1);
        checkOutput("asyncRstOp", {28'b0, bus.alu_op}, 0);
        RST = 1'b0;
        bus.out_ready = 1;
        step();

        for (int i = 0; i < 20 && expQ.size() != 0; i++) step();
        checkOutput("drainQueue", expQ.size(), 0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage that sits directly upstream of the ALU.
- Holds one decoded instruction and resolves forwarding from the MEM and WB stages.
- Applies immediate, shift-amount and LUI selection, then drives the ALU's portA, portB and op.
- Uses a valid/ready handshake on both sides and stalls on load-use hazards.

Parameters:
WIDTH, 32, datapath width
RADDR, 5, register address width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept
in_rs_addr, in_rt_addr, in_dest  in  RADDR each  source/destination register numbers
in_rs_data, in_rt_data  in  WIDTH each  register file read data
in_imm  in  16  instruction immediate
in_shamt  in  5  shift amount
in_aluop  in  4  aluop_t
in_alusrc  in  2  portB select: 0 rt, 1 sign-ext imm, 2 zero-ext imm, 3 imm<<16
in_shift  in  1  portA = shamt, portB = rt
in_regwrite  in  1  instruction writes in_dest
mem_fwd_en, mem_fwd_addr, mem_fwd_data  in  1/RADDR/WIDTH  MEM-stage result
mem_is_load  in  1  MEM-stage data not yet available
wb_fwd_en, wb_fwd_addr, wb_fwd_data  in  1/RADDR/WIDTH  WB-stage result
flush  in  1  squash held instruction
out_valid  out  1  ALU inputs valid
out_ready  in  1  EX/MEM accepts
alu_portA, alu_portB  out  WIDTH each  ALU operands
alu_op  out  4  ALU op
out_dest  out  RADDR  held destination register
out_regwrite  out  1  held write enable
out_store_data  out  WIDTH  forwarded rt value, for stores

Behaviour:
- State: single slot, full flag plus held fields.
- Reset: full=0 and all held fields 0, giving out_valid=0, alu_portA/portB=0, alu_op=0, out_dest=0, out_regwrite=0, out_store_data=0.
- Asynchronous assert clears the slot mid-operation; a transfer in flight is lost.
- in_ready = !full | (out_valid & out_ready), combinational.
- Capture: in_valid & in_ready at the rising edge loads all in_* fields and sets full.
- Release: out_valid & out_ready without capture clears full.
- Pass-through: capture and release in the same cycle replaces the slot; throughput is 1/cycle, latency is 1 cycle.
- flush: highest priority. At the next edge full=0; a simultaneous capture is dropped. in_ready stays as computed.
- Forwarding is combinational from held values. Per source (rs, rt):
  - MEM match (mem_fwd_en & addr==src & src!=0) wins.
  - Else WB match.
  - Else the held value.
  - Register 0 always reads 0.
- Hazard: a MEM match with mem_is_load=1 on any used source forces out_valid=0.
  - Used sources: rs unless in_shift; rt if alusrc==0 or in_shift, or for store data.
- Refresh: each cycle the slot is full and not released, a WB match overwrites the held rs/rt data, so values are not lost once WB retires.
- out_valid = full & !hazard & !flush.
- Operand select:
  - in_shift: portA = {27'b0, shamt}, portB = fwd_rt.
  - Otherwise portA = fwd_rs and portB per alusrc: sign-extend imm, zero-extend imm, or {imm, 16'b0}.
- out_store_data = fwd_rt regardless of alusrc.
- alu_op = held aluop.
- When empty, outputs hold their last values; consumers qualify them with out_valid.
- Stall (out_ready=0): slot holds; outputs may still change as forwarding sources change.

Test Plan:
- Reset mid-transfer: RST pulse while full -> out_valid=0, alu_portA=0, in_ready=1 immediately, without waiting for a clock edge.
- ADDI: rs=3, data 0x10, imm 0xFFFF, alusrc=1, aluop ADD -> next cycle portA=0x10, portB=0xFFFFFFFF, out_valid=1.
- MEM-over-WB priority: held rs=5, MEM fwd r5=0xAAAA, WB fwd r5=0xBBBB -> portA=0xAAAA; with MEM disabled -> 0xBBBB; with rs=0 and both matching -> 0.
- Load-use: mem_is_load=1, mem_fwd_addr=rt=7, alusrc=0 -> out_valid=0 for that cycle. Next cycle WB fwd r7=0x1234 with MEM cleared -> out_valid=1, portB=0x1234, value persists after WB drops.
- Back-pressure/throughput: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, slot unchanged. Then out_ready=1 for 4 cycles -> 4 transfers, no bubbles.
- SLL/LUI and flush: in_shift, shamt=4, rt=0x1 -> portA=4, portB=1. LUI imm 0x1234 -> portB=0x12340000. flush with in_valid=1 -> out_valid=0 next cycle, incoming dropped.
